// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result, valid/ready handshake, iterative shifter
// and branch predicate. Define ALU_MUL_EN to include the iterative shift-add multiplier.
module alu_mc #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            op_br,
  input  logic            op_mul,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_taken
);

  // state | meaning
  // IDLE  | waiting for an op
  // SHIFT | iterative shift, up to SHIFT_STEP bits per cycle
  // MUL   | shift-add multiply, one multiplier bit per cycle
  // DONE  | result held until out_ready

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;

  localparam logic [3:0] BR_BEQ  = 4'd0;
  localparam logic [3:0] BR_BNE  = 4'd1;
  localparam logic [3:0] BR_BLT  = 4'd4;
  localparam logic [3:0] BR_BGE  = 4'd5;
  localparam logic [3:0] BR_BLTU = 4'd6;
  localparam logic [3:0] BR_BGEU = 4'd7;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef ALU_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q;
  logic            br_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      kind_q;

  logic [XLEN:0]   diff;
  logic            ltu, lt, eq;
  logic [SW-1:0]   shamt;
  logic            is_shift;
  logic            launch_mul;
  logic            accept;
  state_t          launch_state;
  logic [XLEN-1:0] alu_val;
  logic            br_val;
  logic [1:0]      kind_d;
  logic [CW-1:0]   step;
  logic [CW-1:0]   cnt_nx;
  logic [XLEN-1:0] shifted;

  // Shared subtractor: carry-out set means a >= b unsigned, so LTU is its inverse.
  assign diff     = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
  assign ltu      = ~diff[XLEN];
  assign eq       = (diff[XLEN-1:0] == '0);
  assign lt       = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : ltu;
  assign shamt    = b[SW-1:0];
  assign is_shift = ~op_br & ((op == OP_SLL) | (op == OP_SRL) | (op == OP_SRA));

`ifdef ALU_MUL_EN
  assign launch_mul = op_mul;
`else
  logic unused_op_mul;
  assign unused_op_mul = op_mul;
  assign launch_mul    = 1'b0;
`endif

  always_comb begin
    alu_val = '0;
    kind_d  = K_SLL;
    case (op)
      OP_ADD:  alu_val = a + b;
      OP_SUB:  alu_val = diff[XLEN-1:0];
      OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, ltu};
      OP_XOR:  alu_val = a ^ b;
      OP_OR:   alu_val = a | b;
      OP_AND:  alu_val = a & b;
      OP_SLL:  begin alu_val = a; kind_d = K_SLL; end
      OP_SRL:  begin alu_val = a; kind_d = K_SRL; end
      OP_SRA:  begin alu_val = a; kind_d = K_SRA; end
      default: alu_val = '0;
    endcase
  end

  always_comb begin
    br_val = 1'b0;
    case (op)
      BR_BEQ:  br_val = eq;
      BR_BNE:  br_val = ~eq;
      BR_BLT:  br_val = lt;
      BR_BGE:  br_val = ~lt;
      BR_BLTU: br_val = ltu;
      BR_BGEU: br_val = ~ltu;
      default: br_val = 1'b0;
    endcase
  end

  always_comb begin
    step = (cnt_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt_q;
    cnt_nx = cnt_q - step;
    case (kind_q)
      K_SRL:   shifted = acc_q >> step;
      K_SRA:   shifted = $unsigned($signed(acc_q) >>> step);
      default: shifted = acc_q << step;
    endcase
  end

  always_comb begin
    launch_state = S_DONE;
`ifdef ALU_MUL_EN
    if (launch_mul)
      launch_state = S_MUL;
    else
`endif
    if (is_shift && (shamt != '0))
      launch_state = S_SHIFT;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    accept   = in_valid & in_ready;
    case (state_q)
      S_IDLE:  if (accept) state_d = launch_state;
      S_SHIFT: if (cnt_nx == '0) state_d = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:   if (cnt_q == CW'(1)) state_d = S_DONE;
`endif
      S_DONE:  if (out_ready) state_d = accept ? launch_state : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

`ifdef ALU_MUL_EN
  logic [XLEN-1:0] mcand_q, mplier_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (!flush) begin
      if (accept) begin
        mcand_q  <= a;
        mplier_q <= b;
      end else if (state_q == S_MUL) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      kind_q <= K_SLL;
    end else if (!flush) begin
      if (accept) begin
        kind_q <= kind_d;
        cnt_q  <= CW'(shamt);
`ifdef ALU_MUL_EN
        if (launch_mul) begin
          acc_q <= '0;
          br_q  <= 1'b0;
          cnt_q <= CW'(XLEN);
        end else
`endif
        if (op_br) begin
          acc_q <= '0;
          br_q  <= br_val;
        end else begin
          acc_q <= alu_val;
          br_q  <= 1'b0;
        end
      end else if (state_q == S_SHIFT) begin
        acc_q <= shifted;
        cnt_q <= cnt_nx;
      end
`ifdef ALU_MUL_EN
      else if (state_q == S_MUL) begin
        acc_q <= acc_q + (mplier_q[0] ? mcand_q : '0);
        cnt_q <= cnt_q - CW'(1);
      end
`endif
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = acc_q;
  assign br_taken  = br_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32, SHIFT_STEP=4) against a behavioural model.
module tb_alu_mc;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SLL = 4'd1, OP_SLT = 4'd2, OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_OR = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8, OP_SUB = 4'd9;
  localparam logic [3:0] BR_BEQ = 4'd0, BR_BNE = 4'd1, BR_BLT = 4'd4, BR_BGE = 4'd5;
  localparam logic [3:0] BR_BLTU = 4'd6, BR_BGEU = 4'd7;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, op_br, op_mul, out_valid, out_ready, br_taken;
  logic [3:0] op;
  logic [31:0] a, b, result;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_br(op_br), .op_mul(op_mul), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .br_taken(br_taken)
  );

  function automatic void model(input logic [3:0] f_op, input logic f_br, input logic f_mul,
                                input logic [31:0] fa, input logic [31:0] fb,
                                output logic [31:0] r, output logic t, output int lat);
    int sh;
    sh  = int'(fb[4:0]);
    r   = 32'd0;
    t   = 1'b0;
    lat = 1;
`ifdef ALU_MUL_EN
    if (f_mul) begin
      r   = fa * fb;
      lat = 33;
      return;
    end
`else
    if (f_mul) lat = 1;
`endif
    if (f_br) begin
      case (f_op)
        BR_BEQ:  t = (fa == fb);
        BR_BNE:  t = (fa != fb);
        BR_BLT:  t = ($signed(fa) < $signed(fb));
        BR_BGE:  t = ($signed(fa) >= $signed(fb));
        BR_BLTU: t = (fa < fb);
        BR_BGEU: t = (fa >= fb);
        default: t = 1'b0;
      endcase
    end else begin
      case (f_op)
        OP_ADD:  r = fa + fb;
        OP_SUB:  r = fa - fb;
        OP_SLT:  r = ($signed(fa) < $signed(fb)) ? 32'd1 : 32'd0;
        OP_SLTU: r = (fa < fb) ? 32'd1 : 32'd0;
        OP_XOR:  r = fa ^ fb;
        OP_OR:   r = fa | fb;
        OP_AND:  r = fa & fb;
        OP_SLL:  r = fa << sh;
        OP_SRL:  r = fa >> sh;
        OP_SRA:  r = $unsigned($signed(fa) >>> sh);
        default: r = 32'd0;
      endcase
      if ((f_op == OP_SLL || f_op == OP_SRL || f_op == OP_SRA) && sh != 0)
        lat = 1 + (sh + 3) / 4;
    end
  endfunction

  task automatic run_op(input string tag, input logic [3:0] t_op, input logic t_br,
                        input logic t_mul, input logic [31:0] ta, input logic [31:0] tb_);
    logic [31:0] er;
    logic et;
    int el, lat, w;
    model(t_op, t_br, t_mul, ta, tb_, er, et, el);
    @(negedge clk);
    op = t_op; op_br = t_br; op_mul = t_mul; a = ta; b = tb_;
    in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: in_ready=%b required 1", tag, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op_mul = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    n_cmp++;
    if (result !== er) begin
      n_fail++;
      $display("FAIL %s result: got %h required %h (op=%0d br=%b a=%h b=%h)", tag, result, er, t_op, t_br, ta, tb_);
    end
    n_cmp++;
    if (br_taken !== et) begin
      n_fail++;
      $display("FAIL %s br_taken: got %b required %b (op=%0d a=%h b=%h)", tag, br_taken, et, t_op, ta, tb_);
    end
    n_cmp++;
    if (lat != el) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", tag, lat, el);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; op_br = 1'b0; op_mul = 1'b0; a = '0; b = '0;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 32'd0 || br_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: out_valid=%b result=%h br_taken=%b required 0/0/0", out_valid, result, br_taken);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    op = OP_SRA; op_br = 1'b0; a = 32'h8000_0000; b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midshift_busy: out_valid=%b required 0", out_valid);
    end
    #2; rst_n = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_midshift: out_valid=%b result=%h required 0/0", out_valid, result);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    logic [31:0] exp_r [3];
    ops = '{OP_ADD, OP_SUB, OP_SLTU};
    as  = '{32'd5, 32'd3, 32'd1};
    bs  = '{32'd7, 32'd5, 32'hFFFF_FFFF};
    exp_r = '{32'd12, 32'hFFFF_FFFE, 32'd1};
    @(negedge clk);
    out_ready = 1'b1; op_br = 1'b0; op_mul = 1'b0;
    op = ops[0]; a = as[0]; b = bs[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== exp_r[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: out_valid=%b result=%h required 1/%h", i, out_valid, result, exp_r[i]);
      end
      if (i < 2) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready_%0d: got %b required 1", i, in_ready);
        end
        op = ops[i+1]; a = as[i+1]; b = bs[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_shift();
    run_op("sra_31", OP_SRA, 1'b0, 1'b0, 32'h8000_0000, 32'd31);
    run_op("sll_0", OP_SLL, 1'b0, 1'b0, 32'd1, 32'd0);
    run_op("srl_36", OP_SRL, 1'b0, 1'b0, 32'h0000_00F0, 32'd36);
    run_op("sll_32", OP_SLL, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd32);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] sop;
      sop = (i % 3 == 0) ? OP_SLL : ((i % 3 == 1) ? OP_SRL : OP_SRA);
      run_op("shift_rand", sop, 1'b0, 1'b0, $urandom, $urandom);
    end
  endtask

  task automatic test_branch();
    run_op("blt_neg", BR_BLT, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("bltu_neg", BR_BLTU, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("beq_9", BR_BEQ, 1'b1, 1'b0, 32'd9, 32'd9);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      run_op("br_rand", 4'(i), 1'b1, 1'b0, ra, rb);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    op = OP_ADD; op_br = 1'b0; op_mul = 1'b0; a = 32'd100; b = 32'd23;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    op = OP_SUB; a = 32'd50; b = 32'd8;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'd123 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out_valid=%b result=%h in_ready=%b required 1/%h/0", i, out_valid, result, in_ready, 32'd123);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'd42) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b result=%h required 1/%h", out_valid, result, 32'd42);
    end
  endtask

  task automatic test_flush();
    logic seen;
    @(negedge clk);
    op = OP_SRL; op_br = 1'b0; a = $urandom; b = 32'd31; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_shift: out_valid seen=%b required 0", seen);
    end
    run_op("after_flush", OP_XOR, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_0000);
    @(negedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b required 0", in_ready);
    end
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_beats_accept: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_mul();
`ifdef ALU_MUL_EN
    run_op("mul_ffff_3", OP_ADD, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3);
    for (int i = 0; i < 4; i++)
      run_op("mul_rand", 4'($urandom_range(0, 15)), 1'b0, 1'b1, $urandom, $urandom);
`else
    run_op("mul_off_add", OP_ADD, 1'b0, 1'b1, 32'd2, 32'd2);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_op("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, $urandom, $urandom);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shift();
    test_branch();
    test_backpressure();
    test_flush();
    test_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
